// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: ID/EX hazard inputs and pipeline control outputs.
// The controller connects through the slave modport; the driver side uses master.
interface pipeline_hazard_controller_if;
   logic       id_valid;
   logic       id_reads_a;
   logic       id_reads_b;
   logic       id_jump;
   logic       ex_valid;
   logic       ex_load;
   logic       ex_write_a;
   logic       ex_write_b;
   logic       ex_branch_taken;
   logic       pc_en;
   logic [1:0] pc_sel;
   logic       if_id_en;
   logic       if_id_flush;
   logic       id_ex_bubble;
   logic [1:0] ctrl_state;

   modport slave (
      input  id_valid, id_reads_a, id_reads_b, id_jump,
      input  ex_valid, ex_load, ex_write_a, ex_write_b, ex_branch_taken,
      output pc_en, pc_sel, if_id_en, if_id_flush, id_ex_bubble, ctrl_state
   );

   modport master (
      output id_valid, id_reads_a, id_reads_b, id_jump,
      output ex_valid, ex_load, ex_write_a, ex_write_b, ex_branch_taken,
      input  pc_en, pc_sel, if_id_en, if_id_flush, id_ex_bubble, ctrl_state
   );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the fetch/decode/execute pipeline (load-use, jump, taken branch).
// Optional perf counters (stall_cnt/flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller #(
   parameter int LOAD_STALL_CYCLES     = 1,
   parameter int REDIRECT_FLUSH_CYCLES = 1,
   parameter int CNT_W                 = 4,
   parameter int PERF_W                = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   pipeline_hazard_controller_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0]           stall_cnt,
   output logic [PERF_W-1:0]           flush_cnt
`endif
);

   if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 15 ||
       REDIRECT_FLUSH_CYCLES < 0 || REDIRECT_FLUSH_CYCLES > 15 ||
       CNT_W < 4 || PERF_W < 1) begin : g_param_chk
      $error("pipeline_hazard_controller: parameter out of range");
   end

   typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_e;

   // The entry cycle counts as one, so the counter reload is length-2 / length-1.
   localparam logic [CNT_W-1:0] STALL_LD =
      (LOAD_STALL_CYCLES > 1) ? CNT_W'(LOAD_STALL_CYCLES - 2) : '0;
   localparam logic [CNT_W-1:0] FLUSH_LD =
      (REDIRECT_FLUSH_CYCLES > 0) ? CNT_W'(REDIRECT_FLUSH_CYCLES - 1) : '0;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             brt, lu;
   logic             pc_en, if_id_en, if_id_flush, id_ex_bubble;
   logic [1:0]       pc_sel;

   assign brt = hz.ex_valid & hz.ex_branch_taken;
   assign lu  = hz.id_valid & hz.ex_valid & hz.ex_load &
                ((hz.id_reads_a & hz.ex_write_a) | (hz.id_reads_b & hz.ex_write_b));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (brt) begin
         if (REDIRECT_FLUSH_CYCLES == 0) begin
            state_d = RUN;
            cnt_d   = '0;
         end else begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LD;
         end
      end else begin
         case (state_q)
            RUN: begin
               if (lu && (LOAD_STALL_CYCLES > 1)) begin
                  state_d = STALL;
                  cnt_d   = STALL_LD;
               end
            end
            STALL, FLUSH: begin
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      pc_en        = 1'b1;
      pc_sel       = 2'b00;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      if (!reset) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (brt) begin
         pc_sel       = 2'b10;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (lu) begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_bubble = 1'b1;
               end else if (hz.id_valid && hz.id_jump) begin
                  pc_sel      = 2'b01;
                  if_id_flush = 1'b1;
               end
            end
            STALL: begin
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_bubble = 1'b1;
            end
            FLUSH: begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign hz.pc_en        = pc_en;
   assign hz.pc_sel       = pc_sel;
   assign hz.if_id_en     = if_id_en;
   assign hz.if_id_flush  = if_id_flush;
   assign hz.id_ex_bubble = id_ex_bubble;
   assign hz.ctrl_state   = state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_en && (stall_cnt_q != '1))      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
         if (if_id_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed vector table, reset corner cases,
// then randomized traffic against a remaining-cycles reference model.
module tb_pipeline_hazard_controller;
   localparam int L = 3;
   localparam int R = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipeline_hazard_controller_if hz();
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cnt, flush_cnt;
`endif

   pipeline_hazard_controller #(
      .LOAD_STALL_CYCLES(L), .REDIRECT_FLUSH_CYCLES(R), .CNT_W(4), .PERF_W(16)
   ) dut (
      .clk(clk), .reset(reset), .hz(hz)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   // inputs: {id_valid,reads_a,reads_b,jump,ex_valid,load,write_a,write_b,branch_taken}
   // outputs: {pc_en,pc_sel[1:0],if_id_en,if_id_flush,id_ex_bubble,ctrl_state[1:0]}
   typedef struct {
      logic [8:0] in;
      logic [7:0] exp;
      string      name;
   } vec_t;

   int n_pass = 0, n_total = 0;
   int stall_rem = 0, flush_rem = 0;
   int m_stall = 0, m_flush = 0;

   function automatic logic [7:0] E(bit pe, bit [1:0] sel, bit en, bit fl, bit bu, bit [1:0] st);
      return {pe, sel, en, fl, bu, st};
   endfunction

   function automatic logic [7:0] outs();
      return {hz.pc_en, hz.pc_sel, hz.if_id_en, hz.if_id_flush, hz.id_ex_bubble, hz.ctrl_state};
   endfunction

   task automatic set_in(input logic [8:0] v);
      {hz.id_valid, hz.id_reads_a, hz.id_reads_b, hz.id_jump, hz.ex_valid,
       hz.ex_load, hz.ex_write_a, hz.ex_write_b, hz.ex_branch_taken} = v;
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%b exp=%b", name, got, exp);
   endtask

   // Model: a redirect owns the front end for 1+R cycles, a load-use freezes it for L cycles.
   task automatic model(input logic [8:0] v, output logic [7:0] e, input bit advance);
      bit idv, ra, rb, jmp, exv, ld, wa, wb, bt, brt, lu;
      bit [1:0] st;
      {idv, ra, rb, jmp, exv, ld, wa, wb, bt} = v;
      brt = exv & bt;
      lu  = idv & exv & ld & ((ra & wa) | (rb & wb));
      st  = (stall_rem > 0) ? 2'd1 : (flush_rem > 0) ? 2'd2 : 2'd0;
      if (brt)                e = E(1, 2'd2, 1, 1, 1, st);
      else if (stall_rem > 0) e = E(0, 2'd0, 0, 0, 1, st);
      else if (flush_rem > 0) e = E(1, 2'd0, 1, 1, 1, st);
      else if (lu)            e = E(0, 2'd0, 0, 0, 1, st);
      else if (idv & jmp)     e = E(1, 2'd1, 1, 1, 0, st);
      else                    e = E(1, 2'd0, 1, 0, 0, st);
      if (advance) begin
         if (!e[7]) m_stall++;
         if (e[3])  m_flush++;
         if (brt) begin
            stall_rem = 0;
            flush_rem = R;
         end else if (stall_rem > 0) stall_rem--;
         else if (flush_rem > 0)     flush_rem--;
         else if (lu)                stall_rem = L - 1;
      end
   endtask

   // One cycle: drive at posedge+1, check at negedge, model advances with the edge.
   task automatic cyc(input logic [8:0] v, input string name, input bit use_t, input logic [7:0] texp);
      logic [7:0] mexp;
      set_in(v);
      model(v, mexp, 1'b0);
      @(negedge clk);
      if (use_t) check(name, {8'h0, outs()}, {8'h0, texp});
      check({"model_", name}, {8'h0, outs()}, {8'h0, mexp});
`ifdef HAZARD_PERF_CNT_EN
      check({"stall_cnt_", name}, stall_cnt, 16'(m_stall));
      check({"flush_cnt_", name}, flush_cnt, 16'(m_flush));
`endif
      model(v, mexp, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic mid_reset(input string name);
      reset = 1'b0;
      #1;
      check({"reset_", name}, {8'h0, outs()}, {8'h0, E(0, 2'd0, 0, 1, 1, 2'd0)});
      stall_rem = 0; flush_rem = 0; m_stall = 0; m_flush = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc(9'b0, {"after_", name}, 1'b1, E(1, 2'd0, 1, 0, 0, 2'd0));
   endtask

   vec_t tbl[$];

   initial begin
      tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, E(1,0,1,0,0,0), "idle"});
      tbl.push_back('{9'b1_1_0_0_1_1_0_1_0, E(1,0,1,0,0,0), "wb_vs_ra_no_stall"});
      tbl.push_back('{9'b1_0_0_1_0_0_0_0_0, E(1,1,1,1,0,0), "jump"});
      tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, E(1,0,1,0,0,0), "after_jump"});
      tbl.push_back('{9'b0_0_0_1_0_0_0_0_0, E(1,0,1,0,0,0), "jump_not_valid"});
      tbl.push_back('{9'b1_1_0_0_1_1_1_0_0, E(0,0,0,0,1,0), "lu_a"});
      tbl.push_back('{9'b1_0_0_1_0_0_0_0_0, E(0,0,0,0,1,1), "stall1_jump_ignored"});
      tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, E(0,0,0,0,1,1), "stall2"});
      tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, E(1,0,1,0,0,0), "stall_done"});
      tbl.push_back('{9'b1_0_1_0_1_1_0_1_0, E(0,0,0,0,1,0), "lu_b"});
      tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, E(0,0,0,0,1,1), "lu_b_s1"});
      tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, E(0,0,0,0,1,1), "lu_b_s2"});
      tbl.push_back('{9'b1_1_0_1_1_1_1_0_1, E(1,2,1,1,1,0), "brt_lu_jump"});
      tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, E(1,0,1,1,1,2), "flush1"});
      tbl.push_back('{9'b0_0_0_0_1_0_0_0_1, E(1,2,1,1,1,2), "brt_in_flush"});
      tbl.push_back('{9'b1_0_0_1_0_0_0_0_0, E(1,0,1,1,1,2), "reflush1"});
      tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, E(1,0,1,1,1,2), "reflush2"});
      tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, E(1,0,1,0,0,0), "flush_done"});
      tbl.push_back('{9'b0_0_0_0_0_0_0_0_1, E(1,0,1,0,0,0), "bt_no_exv"});
      tbl.push_back('{9'b0_1_0_0_1_1_1_0_0, E(1,0,1,0,0,0), "lu_no_idv"});
      tbl.push_back('{9'b1_1_0_0_1_1_1_0_0, E(0,0,0,0,1,0), "lu_pre_brt"});
      tbl.push_back('{9'b0_0_0_0_1_0_0_0_1, E(1,2,1,1,1,1), "brt_in_stall"});
      tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, E(1,0,1,1,1,2), "bs_flush1"});
      tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, E(1,0,1,1,1,2), "bs_flush2"});
      tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, E(1,0,1,0,0,0), "bs_done"});

      reset = 1'b0;
      set_in(9'b0);
      #1;
      check("reset_hold", {8'h0, outs()}, {8'h0, E(0, 2'd0, 0, 1, 1, 2'd0)});
`ifdef HAZARD_PERF_CNT_EN
      check("reset_perf", {stall_cnt[7:0], flush_cnt[7:0]}, 16'h0);
`endif
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      cyc(9'b0, "first_after_reset", 1'b1, E(1, 2'd0, 1, 0, 0, 2'd0));

      foreach (tbl[i]) cyc(tbl[i].in, tbl[i].name, 1'b1, tbl[i].exp);

      cyc(9'b1_1_0_0_1_1_1_0_0, "lu_pre_reset", 1'b1, E(0, 2'd0, 0, 0, 1, 2'd0));
      mid_reset("mid_stall");
      cyc(9'b0_0_0_0_1_0_0_0_1, "brt_pre_reset", 1'b1, E(1, 2'd2, 1, 1, 1, 2'd0));
      mid_reset("mid_flush");

      for (int c = 0; c < 3000; c++) begin
         logic [8:0] v;
         v = 9'($urandom);
         v[0] = ($urandom_range(0, 7) == 0);
         cyc(v, "rand", 1'b0, 8'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
